ibex_rf_writeback: RTL and testbench

Write-side front end for the flop-based register file. Collects ALU results (same-cycle) and load responses (out of band, in order) and turns them into a single registered write port (address, data, enable) driving the register file. Tracks destinations of outstanding loads and flags read-after-write hazards on the decode-stage read addresses. Sits between the ALU/LSU writeback paths and the register file write port.

---
 rtl/ibex_rf_pkg.sv | 34 +++
 rtl/ibex_rf_writeback_if.sv | 55 +++++
 rtl/ibex_rf_wb_queue.sv | 92 +++++++++
 rtl/ibex_rf_writeback.sv | 155 +++++++++++++++
 tb/tb_ibex_rf_writeback.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibex_rf_pkg                                                                |
// | Shared constants and helpers for the register-file writeback front end.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ibex_rf_pkg;

    localparam int unsigned ADDR_WIDTH_RV32I = 5;
    localparam int unsigned ADDR_WIDTH_RV32E = 4;

    // Physical address ports are always 5 bits wide; RV32E only narrows the legal range.
    localparam int unsigned REG_ADDR_W = ADDR_WIDTH_RV32I;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_ORPHAN_RSP   = 2'd1,
        ERR_ILLEGAL_ADDR = 2'd2
    } err_cause_e;

    function automatic int unsigned addr_width(input bit rv32e);
        return rv32e ? ADDR_WIDTH_RV32E : ADDR_WIDTH_RV32I;
    endfunction

    function automatic int unsigned num_words(input bit rv32e);
        return 32'd1 << addr_width(rv32e);
    endfunction

    function automatic logic addr_illegal(input logic [REG_ADDR_W-1:0] addr, input bit rv32e);
        return (32'(addr) >= num_words(rv32e));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_rf_writeback_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibex_rf_writeback_if                                                       |
// | ALU / LSU writeback, decode read-address and register-file write bundle.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ibex_rf_writeback_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LoadDepth = 2
);
    localparam int unsigned CntW = $clog2(LoadDepth + 1);

    logic                 alu_valid_i;
    logic                 alu_ready_o;
    logic [4:0]           alu_waddr_i;
    logic [DataWidth-1:0] alu_wdata_i;

    logic                 lsu_req_valid_i;
    logic                 lsu_req_ready_o;
    logic [4:0]           lsu_req_waddr_i;
    logic                 lsu_rsp_valid_i;
    logic [DataWidth-1:0] lsu_rsp_rdata_i;
    logic                 lsu_rsp_err_i;

    logic [4:0]           raddr_a_i;
    logic [4:0]           raddr_b_i;
    logic                 hazard_a_o;
    logic                 hazard_b_o;

    logic [4:0]           rf_waddr_o;
    logic [DataWidth-1:0] rf_wdata_o;
    logic                 rf_we_o;
    logic [CntW-1:0]      outstanding_o;
    logic                 err_o;

    modport master (
        output alu_valid_i, alu_waddr_i, alu_wdata_i,
        output lsu_req_valid_i, lsu_req_waddr_i,
        output lsu_rsp_valid_i, lsu_rsp_rdata_i, lsu_rsp_err_i,
        output raddr_a_i, raddr_b_i,
        input  alu_ready_o, lsu_req_ready_o, hazard_a_o, hazard_b_o,
        input  rf_waddr_o, rf_wdata_o, rf_we_o, outstanding_o, err_o
    );

    modport slave (
        input  alu_valid_i, alu_waddr_i, alu_wdata_i,
        input  lsu_req_valid_i, lsu_req_waddr_i,
        input  lsu_rsp_valid_i, lsu_rsp_rdata_i, lsu_rsp_err_i,
        input  raddr_a_i, raddr_b_i,
        output alu_ready_o, lsu_req_ready_o, hazard_a_o, hazard_b_o,
        output rf_waddr_o, rf_wdata_o, rf_we_o, outstanding_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/ibex_rf_wb_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibex_rf_wb_queue                                                           |
// | In-order FIFO of outstanding load destinations with per-entry visibility.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ibex_rf_wb_queue #(
    parameter  int unsigned LoadDepth = 2,
    parameter  int unsigned AddrWidth = 5,
    localparam int unsigned CntW      = $clog2(LoadDepth + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                push_i,
    input  logic [AddrWidth-1:0]                push_addr_i,
    input  logic                                pop_i,
    output logic                                full_o,
    output logic                                empty_o,
    output logic [CntW-1:0]                     count_o,
    output logic [AddrWidth-1:0]                head_addr_o,
    output logic [LoadDepth-1:0]                entry_valid_o,
    output logic [LoadDepth-1:0][AddrWidth-1:0] entry_addr_o
);

    localparam int unsigned PtrW = (LoadDepth > 1) ? $clog2(LoadDepth) : 1;
    localparam logic [PtrW-1:0] LAST_PTR = PtrW'(LoadDepth - 1);

    logic [PtrW-1:0]                     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]                     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]                     count_q, count_d;
    logic [LoadDepth-1:0]                valid_q, valid_d;
    logic [LoadDepth-1:0][AddrWidth-1:0] addr_q, addr_d;
    logic                                do_push;
    logic                                do_pop;

    // Pointers wrap at LoadDepth, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full_o        = (count_q == CntW'(LoadDepth));
    assign empty_o       = (count_q == '0);
    assign count_o       = count_q;
    assign head_addr_o   = addr_q[rd_ptr_q];
    assign entry_valid_o = valid_q;
    assign entry_addr_o  = addr_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        // Pop clears before push sets; slots only coincide when empty or full,
        // and neither state allows both operations together.
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end
        if (do_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = push_addr_i;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            addr_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ibex_rf_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ibex_rf_writeback                                                          |
// | Merges ALU and load writebacks into one registered register-file port.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ibex_rf_writeback
    import ibex_rf_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned LoadDepth = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ibex_rf_writeback_if.slave  bus
);

    localparam int unsigned CntW = $clog2(LoadDepth + 1);

    logic                                 q_full;
    logic                                 q_empty;
    logic [CntW-1:0]                      q_count;
    logic [REG_ADDR_W-1:0]                q_head_addr;
    logic [LoadDepth-1:0]                 q_entry_valid;
    logic [LoadDepth-1:0][REG_ADDR_W-1:0] q_entry_addr;

    logic                  push;
    logic                  pop;
    logic                  orphan_rsp;
    logic                  alu_waw;
    logic                  alu_ready;
    logic                  alu_accept;
    logic                  queued_a;
    logic                  queued_b;

    logic                  wr_sel;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DataWidth-1:0]  wr_data;

    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DataWidth-1:0]  rf_wdata_q, rf_wdata_d;
    err_cause_e            err_cause_q, err_cause_d;

    // Ready depends only on occupancy, so a full queue can still pop in the same cycle.
    assign push       = bus.lsu_req_valid_i && !q_full;
    assign pop        = bus.lsu_rsp_valid_i && !q_empty;
    assign orphan_rsp = bus.lsu_rsp_valid_i && q_empty;

    ibex_rf_wb_queue #(
        .LoadDepth (LoadDepth),
        .AddrWidth (REG_ADDR_W)
    ) u_queue (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (push),
        .push_addr_i   (bus.lsu_req_waddr_i),
        .pop_i         (pop),
        .full_o        (q_full),
        .empty_o       (q_empty),
        .count_o       (q_count),
        .head_addr_o   (q_head_addr),
        .entry_valid_o (q_entry_valid),
        .entry_addr_o  (q_entry_addr)
    );

    always_comb begin
        alu_waw  = 1'b0;
        queued_a = 1'b0;
        queued_b = 1'b0;
        for (int i = 0; i < int'(LoadDepth); i++) begin
            if (q_entry_valid[i]) begin
                if (q_entry_addr[i] == bus.alu_waddr_i) alu_waw  = 1'b1;
                if (q_entry_addr[i] == bus.raddr_a_i)   queued_a = 1'b1;
                if (q_entry_addr[i] == bus.raddr_b_i)   queued_b = 1'b1;
            end
        end
        // x0 never carries a real dependency.
        if (bus.alu_waddr_i == '0) alu_waw = 1'b0;
    end

    // Any returning response owns the write port, so the ALU waits that cycle.
    assign alu_ready  = !bus.lsu_rsp_valid_i && !alu_waw;
    assign alu_accept = bus.alu_valid_i && alu_ready;

    always_comb begin
        wr_sel      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        err_cause_d = ERR_NONE;
        if (orphan_rsp) begin
            err_cause_d = ERR_ORPHAN_RSP;
        end else if (pop) begin
            if (addr_illegal(q_head_addr, RV32E)) begin
                err_cause_d = ERR_ILLEGAL_ADDR;
            end else if (!bus.lsu_rsp_err_i) begin
                wr_sel  = 1'b1;
                wr_addr = q_head_addr;
                wr_data = bus.lsu_rsp_rdata_i;
            end
        end else if (alu_accept) begin
            if (addr_illegal(bus.alu_waddr_i, RV32E)) begin
                err_cause_d = ERR_ILLEGAL_ADDR;
            end else begin
                wr_sel  = 1'b1;
                wr_addr = bus.alu_waddr_i;
                wr_data = bus.alu_wdata_i;
            end
        end
        // Illegal load destinations still enqueue so later responses stay matched.
        if (push && addr_illegal(bus.lsu_req_waddr_i, RV32E) && err_cause_d == ERR_NONE) begin
            err_cause_d = ERR_ILLEGAL_ADDR;
        end
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (wr_sel && wr_addr != '0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wr_addr;
            rf_wdata_d = wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            err_cause_q <= ERR_NONE;
        end else begin
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            err_cause_q <= err_cause_d;
        end
    end

    assign bus.alu_ready_o     = alu_ready;
    assign bus.lsu_req_ready_o = !q_full;
    assign bus.hazard_a_o      = (bus.raddr_a_i != '0) &&
                                 (queued_a || (rf_we_q && rf_waddr_q == bus.raddr_a_i));
    assign bus.hazard_b_o      = (bus.raddr_b_i != '0) &&
                                 (queued_b || (rf_we_q && rf_waddr_q == bus.raddr_b_i));
    assign bus.rf_we_o         = rf_we_q;
    assign bus.rf_waddr_o      = rf_waddr_q;
    assign bus.rf_wdata_o      = rf_wdata_q;
    assign bus.outstanding_o   = q_count;
    assign bus.err_o           = (err_cause_q != ERR_NONE);

endmodule
`default_nettype wire

// File: tb/tb_ibex_rf_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ibex_rf_writeback                                                       |
// | Directed vector bench for the register-file writeback front end.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ibex_rf_writeback;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ibex_rf_writeback_if #(.DataWidth(32), .LoadDepth(2)) bus   ();
    ibex_rf_writeback_if #(.DataWidth(32), .LoadDepth(2)) bus_e ();

    ibex_rf_writeback #(.DataWidth(32), .RV32E(1'b0), .LoadDepth(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    ibex_rf_writeback #(.DataWidth(32), .RV32E(1'b1), .LoadDepth(2)) dut_e (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_e)
    );

    typedef struct packed {
        logic        alu_v;
        logic [4:0]  alu_a;
        logic [31:0] alu_d;
        logic        req_v;
        logic [4:0]  req_a;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        rsp_e;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        e_ar;
        logic        e_rr;
        logic        e_ha;
        logic        e_hb;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [1:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d actual=0x%0h required=0x%0h", name, row, act, exp);
        end
    endtask

    task automatic idle_main();
        bus.alu_valid_i     = 1'b0;
        bus.alu_waddr_i     = 5'd0;
        bus.alu_wdata_i     = 32'h0;
        bus.lsu_req_valid_i = 1'b0;
        bus.lsu_req_waddr_i = 5'd0;
        bus.lsu_rsp_valid_i = 1'b0;
        bus.lsu_rsp_rdata_i = 32'h0;
        bus.lsu_rsp_err_i   = 1'b0;
        bus.raddr_a_i       = 5'd0;
        bus.raddr_b_i       = 5'd0;
    endtask

    task automatic idle_e();
        bus_e.alu_valid_i     = 1'b0;
        bus_e.alu_waddr_i     = 5'd0;
        bus_e.alu_wdata_i     = 32'h0;
        bus_e.lsu_req_valid_i = 1'b0;
        bus_e.lsu_req_waddr_i = 5'd0;
        bus_e.lsu_rsp_valid_i = 1'b0;
        bus_e.lsu_rsp_rdata_i = 32'h0;
        bus_e.lsu_rsp_err_i   = 1'b0;
        bus_e.raddr_a_i       = 5'd0;
        bus_e.raddr_b_i       = 5'd0;
    endtask

    task automatic apply(input vec_t v);
        bus.alu_valid_i     = v.alu_v;
        bus.alu_waddr_i     = v.alu_a;
        bus.alu_wdata_i     = v.alu_d;
        bus.lsu_req_valid_i = v.req_v;
        bus.lsu_req_waddr_i = v.req_a;
        bus.lsu_rsp_valid_i = v.rsp_v;
        bus.lsu_rsp_rdata_i = v.rsp_d;
        bus.lsu_rsp_err_i   = v.rsp_e;
        bus.raddr_a_i       = v.ra;
        bus.raddr_b_i       = v.rb;
    endtask

    task automatic check_row(input vec_t v, input int row);
        check("alu_ready",   row, 32'(bus.alu_ready_o),     32'(v.e_ar));
        check("req_ready",   row, 32'(bus.lsu_req_ready_o), 32'(v.e_rr));
        check("hazard_a",    row, 32'(bus.hazard_a_o),      32'(v.e_ha));
        check("hazard_b",    row, 32'(bus.hazard_b_o),      32'(v.e_hb));
        check("rf_we",       row, 32'(bus.rf_we_o),         32'(v.e_we));
        check("outstanding", row, 32'(bus.outstanding_o),   32'(v.e_out));
        check("err",         row, 32'(bus.err_o),           32'(v.e_err));
        if (v.e_we) begin
            check("rf_waddr", row, 32'(bus.rf_waddr_o), 32'(v.e_wa));
            check("rf_wdata", row, bus.rf_wdata_o,      v.e_wd);
        end
    endtask

    initial begin
        // alu_v,a,d | req_v,a | rsp_v,d,e | ra,rb || ar,rr,ha,hb,we,wa,wd,out,err
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd5,5'd0,   1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd5,5'd0,   1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd5,5'd0,   1'b1,1'b1,1'b1,1'b0,1'b1,5'd5,32'hDEADBEEF,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd5,5'd0,   1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b1,5'd3,  1'b0,32'h0,1'b0,  5'd3,5'd7,   1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b1,5'd7,  1'b0,32'h0,1'b0,  5'd3,5'd7,   1'b1,1'b1,1'b1,1'b0,1'b0,5'd0,32'h0,2'd1,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd3,5'd7,   1'b1,1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,2'd2,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b1,32'h11,1'b0, 5'd3,5'd7,   1'b0,1'b0,1'b1,1'b1,1'b0,5'd0,32'h0,2'd2,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b1,32'h22,1'b0, 5'd3,5'd7,   1'b0,1'b1,1'b1,1'b1,1'b1,5'd3,32'h11,2'd1,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd3,5'd7,   1'b1,1'b1,1'b0,1'b1,1'b1,5'd7,32'h22,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b1,5'd4,  1'b0,32'h0,1'b0,  5'd4,5'd6,   1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b1,5'd4,32'hAAAA,     1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd4,5'd6,   1'b0,1'b1,1'b1,1'b0,1'b0,5'd0,32'h0,2'd1,1'b0});
        vecs.push_back('{1'b1,5'd4,32'hAAAA,     1'b0,5'd0,  1'b1,32'h44,1'b0, 5'd4,5'd6,   1'b0,1'b1,1'b1,1'b0,1'b0,5'd0,32'h0,2'd1,1'b0});
        vecs.push_back('{1'b1,5'd4,32'hAAAA,     1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd4,5'd6,   1'b1,1'b1,1'b1,1'b0,1'b1,5'd4,32'h44,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd4,5'd6,   1'b1,1'b1,1'b1,1'b0,1'b1,5'd4,32'hAAAA,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b1,5'd9,  1'b0,32'h0,1'b0,  5'd0,5'd0,   1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b1,5'd6,32'h66,       1'b0,5'd0,  1'b1,32'h99,1'b0, 5'd9,5'd6,   1'b0,1'b1,1'b1,1'b0,1'b0,5'd0,32'h0,2'd1,1'b0});
        vecs.push_back('{1'b1,5'd6,32'h66,       1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd9,5'd6,   1'b1,1'b1,1'b1,1'b0,1'b1,5'd9,32'h99,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd9,5'd6,   1'b1,1'b1,1'b0,1'b1,1'b1,5'd6,32'h66,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b1,5'd10, 1'b0,32'h0,1'b0,  5'd10,5'd0,  1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b1,32'h55,1'b1, 5'd10,5'd0,  1'b0,1'b1,1'b1,1'b0,1'b0,5'd0,32'h0,2'd1,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd10,5'd0,  1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b1,32'h77,1'b0, 5'd0,5'd0,   1'b0,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd0,5'd0,   1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b1});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd0,5'd0,   1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b1,5'd0,32'h1234,     1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd0,5'd0,   1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd0,5'd0,   1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b1,5'd1,  1'b0,32'h0,1'b0,  5'd1,5'd2,   1'b1,1'b1,1'b0,1'b0,1'b0,5'd0,32'h0,2'd0,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b1,5'd2,  1'b0,32'h0,1'b0,  5'd1,5'd2,   1'b1,1'b1,1'b1,1'b0,1'b0,5'd0,32'h0,2'd1,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b1,5'd8,  1'b1,32'hA1,1'b0, 5'd8,5'd2,   1'b0,1'b0,1'b0,1'b1,1'b0,5'd0,32'h0,2'd2,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b1,5'd8,  1'b1,32'hA2,1'b0, 5'd8,5'd2,   1'b0,1'b1,1'b0,1'b1,1'b1,5'd1,32'hA1,2'd1,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b1,32'hA8,1'b0, 5'd8,5'd2,   1'b0,1'b1,1'b1,1'b1,1'b1,5'd2,32'hA2,2'd1,1'b0});
        vecs.push_back('{1'b0,5'd0,32'h0,        1'b0,5'd0,  1'b0,32'h0,1'b0,  5'd8,5'd2,   1'b1,1'b1,1'b1,1'b0,1'b1,5'd8,32'hA8,2'd0,1'b0});

        rst = 1'b1;
        idle_main();
        idle_e();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            #2;
            check_row(vecs[i], i);
            @(negedge clk);
        end

        // Reset with two loads pending, then an orphan response.
        idle_main();
        bus.lsu_req_valid_i = 1'b1;
        bus.lsu_req_waddr_i = 5'd11;
        @(negedge clk);
        bus.lsu_req_waddr_i = 5'd12;
        @(negedge clk);
        idle_main();
        bus.raddr_a_i = 5'd11;
        bus.raddr_b_i = 5'd12;
        #2;
        check("rst_pre_out",  100, 32'(bus.outstanding_o), 32'd2);
        check("rst_pre_haza", 100, 32'(bus.hazard_a_o),    32'd1);
        check("rst_pre_hazb", 100, 32'(bus.hazard_b_o),    32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_out",   101, 32'(bus.outstanding_o),   32'd0);
        check("rst_haza",  101, 32'(bus.hazard_a_o),      32'd0);
        check("rst_hazb",  101, 32'(bus.hazard_b_o),      32'd0);
        check("rst_we",    101, 32'(bus.rf_we_o),         32'd0);
        check("rst_waddr", 101, 32'(bus.rf_waddr_o),      32'd0);
        check("rst_wdata", 101, bus.rf_wdata_o,           32'd0);
        check("rst_err",   101, 32'(bus.err_o),           32'd0);
        check("rst_aready",101, 32'(bus.alu_ready_o),     32'd1);
        check("rst_rready",101, 32'(bus.lsu_req_ready_o), 32'd1);
        bus.lsu_rsp_valid_i = 1'b1;
        bus.lsu_rsp_rdata_i = 32'hBAD;
        @(negedge clk);
        idle_main();
        #2;
        check("orphan_err", 102, 32'(bus.err_o),   32'd1);
        check("orphan_we",  102, 32'(bus.rf_we_o), 32'd0);

        // RV32E instance: x20 is illegal, x5 is fine, illegal load destination still counts.
        bus_e.alu_valid_i = 1'b1;
        bus_e.alu_waddr_i = 5'd20;
        bus_e.alu_wdata_i = 32'h5555;
        #2;
        check("e_ready20", 200, 32'(bus_e.alu_ready_o), 32'd1);
        @(negedge clk);
        bus_e.alu_waddr_i = 5'd5;
        bus_e.alu_wdata_i = 32'hCAFE;
        #2;
        check("e_err20", 201, 32'(bus_e.err_o),   32'd1);
        check("e_we20",  201, 32'(bus_e.rf_we_o), 32'd0);
        @(negedge clk);
        idle_e();
        bus_e.lsu_req_valid_i = 1'b1;
        bus_e.lsu_req_waddr_i = 5'd17;
        #2;
        check("e_err5",   202, 32'(bus_e.err_o),      32'd0);
        check("e_we5",    202, 32'(bus_e.rf_we_o),    32'd1);
        check("e_waddr5", 202, 32'(bus_e.rf_waddr_o), 32'd5);
        check("e_wdata5", 202, bus_e.rf_wdata_o,      32'hCAFE);
        @(negedge clk);
        idle_e();
        #2;
        check("e_push_err", 203, 32'(bus_e.err_o),         32'd1);
        check("e_push_out", 203, 32'(bus_e.outstanding_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
